// File: rtl/hdmi_video_timing.sv
// Raster timing generator for the HDMI output path.
// Produces a pixel-request stream and LAT-cycle delayed de/hsync/vsync/frame_start.
// Counter order within a line/frame: active, front porch, sync, back porch.
module hdmi_video_timing #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int LAT      = 2,
  parameter int H_W      = 12,
  parameter int V_W      = 11
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           run,
  output logic           req_valid,
  output logic [H_W-1:0] req_x,
  output logic [V_W-1:0] req_y,
  output logic           de,
  output logic           hsync,
  output logic           vsync,
  output logic           frame_start,
  output logic           busy
);

  // state | meaning
  // IDLE  | counters held at 0, raster outputs inactive, waiting for run
  // RUN   | h/v advance every cycle; stop honoured only at the last position
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  state_t         state;
  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  logic           busy_q;

  logic           valid_raw;
  logic           hs_raw;
  logic           vs_raw;
  logic           fs_raw;

  // Chain entry bit order: {de, hs, vs, fs}; all-zero is the inactive value.
  logic [LAT-1:0][3:0] chain;

  // State machine and raster counters; a dropped run only takes effect at frame end.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      h      <= '0;
      v      <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          h <= '0;
          v <= '0;
          if (run) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (h == H_LAST) begin
            h <= '0;
            if (v == V_LAST) begin
              v <= '0;
              if (!run) begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end else begin
              v <= v + V_W'(1);
            end
          end else begin
            h <= h + H_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          h      <= '0;
          v      <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Stage-0 position decode straight from the counter registers.
  always_comb begin
    valid_raw = 1'b0;
    hs_raw    = 1'b0;
    vs_raw    = 1'b0;
    fs_raw    = 1'b0;
    if (state == RUN) begin
      valid_raw = (h < H_ACT) && (v < V_ACT);
      hs_raw    = (h >= HS_BEG) && (h < HS_END);
      vs_raw    = (v >= VS_BEG) && (v < VS_END);
      fs_raw    = (h == '0) && (v == '0);
    end
  end

  // Delay chain keeps shifting in IDLE so the tail of the last frame drains out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chain <= '0;
    end else begin
      chain[0] <= {valid_raw, hs_raw, vs_raw, fs_raw};
      for (int i = 1; i < LAT; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign req_valid   = valid_raw;
  assign req_x       = valid_raw ? h : '0;
  assign req_y       = valid_raw ? v : '0;
  assign de          = chain[LAT-1][3];
  assign hsync       = chain[LAT-1][2] ? HS_ON : ~HS_ON;
  assign vsync       = chain[LAT-1][1] ? VS_ON : ~VS_ON;
  assign frame_start = chain[LAT-1][0];
  assign busy        = busy_q;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Scoreboard bench for hdmi_video_timing with a reduced 16x8 raster.
module tb_hdmi_video_timing;

  localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int H_TOTAL = 16, V_TOTAL = 8;
  localparam int LAT = 2;
  localparam int H_W = 12, V_W = 11;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           run = 1'b0;
  logic           req_valid;
  logic [H_W-1:0] req_x;
  logic [V_W-1:0] req_y;
  logic           de, hsync, vsync, frame_start, busy;

  hdmi_video_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1), .VS_POL(1), .LAT(LAT), .H_W(H_W), .V_W(V_W)
  ) dut (
    .clk(clk), .resetn(resetn), .run(run),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .de(de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_fs = -1;
  bit gap_on = 1'b0;

  // reference model
  bit m_st = 1'b0;
  int mh = 0;
  int mv = 0;
  logic [3:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic sb_reset();
    sb_q.delete();
    for (int i = 0; i < LAT; i++) sb_q.push_back(4'b0000);
  endtask

  task automatic model_update(input logic r);
    if (!m_st) begin
      mh = 0;
      mv = 0;
      if (r) m_st = 1'b1;
    end else if (mh == H_TOTAL - 1) begin
      mh = 0;
      if (mv == V_TOTAL - 1) begin
        mv = 0;
        if (!r) m_st = 1'b0;
      end else begin
        mv++;
      end
    end else begin
      mh++;
    end
  endtask

  task automatic compare();
    logic           e_valid, e_hs, e_vs, e_fs;
    logic [H_W-1:0] e_x;
    logic [V_W-1:0] e_y;
    logic [3:0]     e_dly;
    e_valid = m_st && mh < H_ACTIVE && mv < V_ACTIVE;
    e_hs    = m_st && mh >= H_ACTIVE + H_FP && mh < H_ACTIVE + H_FP + H_SYNC;
    e_vs    = m_st && mv >= V_ACTIVE + V_FP && mv < V_ACTIVE + V_FP + V_SYNC;
    e_fs    = m_st && mh == 0 && mv == 0;
    e_x     = e_valid ? H_W'(mh) : '0;
    e_y     = e_valid ? V_W'(mv) : '0;
    chk("req", {7'd0, busy, req_valid, req_x, req_y}, {7'd0, m_st, e_valid, e_x, e_y});
    sb_q.push_back({e_valid, e_hs, e_vs, e_fs});
    e_dly = sb_q.pop_front();
    chk("sync", {28'd0, de, hsync, vsync, frame_start}, {28'd0, e_dly});
    if (frame_start) begin
      if (gap_on && last_fs >= 0) chk("fs_gap", cyc - last_fs, H_TOTAL * V_TOTAL);
      last_fs = cyc;
    end
  endtask

  task automatic tick(input logic r);
    run = r;
    @(posedge clk);
    cyc++;
    if (resetn) model_update(r);
    @(negedge clk);
    compare();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    sb_reset();
    @(negedge clk);
    // reset held, run toggled: nothing may move
    for (int i = 0; i < 6; i++) tick(i[0]);
    chk("rst_hsync", {31'd0, hsync}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    resetn = 1'b1;
    tick(1'b0);
    tick(1'b0);

    // line/frame timing and seamless running across three frames
    gap_on  = 1'b1;
    last_fs = -1;
    for (int i = 0; i < 3 * H_TOTAL * V_TOTAL + 4; i++) tick(1'b1);
    gap_on = 1'b0;

    // stop mid-frame once the model reaches line 2
    for (int i = 0; i < 200 && !(m_st && mv == 2); i++) tick(1'b1);
    for (int i = 0; i < 200 && m_st; i++) tick(1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0);
    chk("busy_after_stop", {31'd0, busy}, 32'd0);
    chk("de_after_stop", {31'd0, de}, 32'd0);

    // stop cancelled by re-asserting run before frame end
    for (int i = 0; i < 20; i++) tick(1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0);
    for (int i = 0; i < 2 * H_TOTAL * V_TOTAL; i++) tick(1'b1);

    // asynchronous reset at (5,1)
    for (int i = 0; i < 300 && !(m_st && mh == 5 && mv == 1); i++) tick(1'b1);
    chk("pre_rst_valid", {31'd0, req_valid}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("async_rst", {25'd0, req_valid, de, hsync, vsync, frame_start, busy, |req_x},
        32'd0);
    m_st = 1'b0;
    mh   = 0;
    mv   = 0;
    sb_reset();
    @(negedge clk);
    compare();
    tick(1'b1);
    resetn = 1'b1;
    for (int i = 0; i < 40; i++) tick(1'b1);
    for (int i = 0; i < 200 && m_st; i++) tick(1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/hdmi_video_timing.md
# hdmi_video_timing

Generates raster timing for the HDMI output path. Runs on the divided pixel clock produced by the HDMI clock generator, with its reset tied to that generator's PLL lock. Produces hsync/vsync/de for the TMDS encoders, plus a pixel-request stream (`req_valid`, `req_x`, `req_y`) that leads the sync/de outputs by a fixed pipeline latency. This lead lets the spectrum frame source fetch pixel data in time. Defaults are 1280x720p60 at 74.25 MHz.

## Interface
Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level
- LAT, 2, cycles from request to matching de/sync; legal range 1..8
- H_W, 12, horizontal counter / req_x width
- V_W, 11, vertical counter / req_y width

Ports:
- clk  in  1  pixel clock (hdmi_clk)
- resetn  in  1  asynchronous, active-low reset (driven from hdmi_clk_lock)
- run  in  1  enable raster generation; sampled every cycle
- req_valid  out  1  current position is an active pixel
- req_x  out  H_W  active column (0 when !req_valid)
- req_y  out  V_W  active row (0 when !req_valid)
- de  out  1  data enable, req_valid delayed by LAT
- hsync  out  1  horizontal sync, delayed by LAT
- vsync  out  1  vertical sync, delayed by LAT
- frame_start  out  1  one-cycle pulse, delayed by LAT, at position (0,0)
- busy  out  1  state is RUN

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL defined analogously. Counter order within a line/frame: active, front porch, sync, back porch.
- Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1):
  - h increments every RUN cycle and wraps to 0.
  - On h wrap, v increments and wraps to 0.
- States:
  - IDLE: counters held at 0; all outputs forced inactive.
  - RUN: counters advance.
- Transitions:
  - IDLE→RUN when run=1 is sampled. The first RUN cycle presents (h,v)=(0,0).
  - RUN→IDLE only at the last position (h=H_TOTAL-1, v=V_TOTAL-1) with run=0.
  - run=0 mid-frame completes the frame. run re-asserted before frame end cancels the stop.
  - run=1 at the last position continues seamlessly to (0,0).
- Stage 0 decode (combinational from the counter registers):
  - req_valid = RUN && h<H_ACTIVE && v<V_ACTIVE
  - req_x/req_y = h/v when req_valid, else 0
  - hs_raw = RUN && H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC
  - vs_raw = RUN && V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (whole lines, edges aligned to h=0)
  - fs_raw = RUN && h=0 && v=0
- de, hsync, vsync and frame_start are {req_valid, hs_raw, vs_raw, fs_raw} passed through a LAT-deep register shift chain. Sync outputs apply polarity: output = raw ? POL : !POL.
- The delay chain keeps shifting in IDLE, so the last frame's tail drains fully after the stop.

## Timing
- Reset values: counters 0, state IDLE, de=0, req_valid=0, req_x=0, req_y=0, frame_start=0, busy=0, hsync=!HS_POL, vsync=!VS_POL. All delay-chain stages hold inactive values.
- Reset is asynchronous assert, synchronous-safe release. Reset mid-frame drops all outputs to reset values immediately. After release, the block waits in IDLE for run.
- Latency: req_* at cycle n correspond to de/hsync/vsync at cycle n+LAT.
- Frame period is exactly H_TOTAL·V_TOTAL cycles while RUN. Line period is H_TOTAL.
- busy rises one cycle after run=1 is sampled in IDLE. It falls the cycle after the last position of a stopping frame.

## Test plan
Small parameters: H 8/2/3/3 (H_TOTAL=16), V 4/1/2/1 (V_TOTAL=8), LAT=2, POL=1.
- Reset: hold resetn=0 -> all outputs at reset values (hsync=vsync=0 with POL=1). Toggle run with resetn=0 -> no change.
- Line timing: run=1 ->
  - req_valid high for 8 cycles per line with req_x 0..7.
  - de follows req_valid 2 cycles later.
  - hsync high for h=10..12 delayed by 2 cycles; period 16.
- Frame timing: run=1 ->
  - vsync high for lines 5..6 (32 cycles).
  - frame_start pulses every 128 cycles.
  - req_y advances 0..3 on active lines.
- Stop mid-frame: drop run at v=2 -> frame completes through (15,7); busy falls. de/hsync/vsync drain 2 cycles later, then stay inactive.
- Seamless run: run held 1 across three frames -> no gap; frame_start spacing exactly 128 cycles.
- Reset mid-frame: assert resetn=0 at (h,v)=(5,1) -> outputs inactive the same cycle. After release with run=1, the first req_valid appears at (0,0) and de follows 2 cycles later.
